// File: rtl/servo_pkg.sv
// Shared servo definitions: position FSM states, angle range and default timing.
package servo_pkg;

  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    MOVENDO = 1'b1
  } estado_posicionador_t;

  localparam int ANGULO_MAX  = 180;
  localparam int CLOCK_HZ    = 50_000_000;
  localparam int PERIODO_PWM = 1_000_000;

  // Angles above the mechanical range are pinned to the end stop.
  function automatic logic [7:0] satura_angulo(input logic [7:0] angulo);
    return (angulo > 8'(ANGULO_MAX)) ? 8'(ANGULO_MAX) : angulo;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with async and sync clear; fim flags the terminal count M-1.
module contador_m #(
  parameter int M = 1_000_000,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [W-1:0] valor;

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      valor <= '0;
    end else if (zera_s) begin
      valor <= '0;
    end else if (conta) begin
      valor <= (valor == W'(M - 1)) ? '0 : valor + 1'b1;
    end
  end

  assign fim = (valor == W'(M - 1));

endmodule

// File: rtl/posicionador_servo.sv
// Slew-rate-limited servo position front end: angle command -> target width,
// width walked toward the target by at most PASSO ticks per step period.
module posicionador_servo
  import servo_pkg::*;
#(
  parameter int LARGURA_MIN   = 50000,
  parameter int LARGURA_MAX   = 100000,
  parameter int PASSO         = 500,
  parameter int PERIODO_PASSO = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [7:0]  pos_angulo,
  output logic [31:0] largura,
  output logic        movendo,
  output logic        chegou
);

  localparam logic [31:0] PASSO_GRAU     = 32'((LARGURA_MAX - LARGURA_MIN) / ANGULO_MAX);
  localparam logic [31:0] LARGURA_CENTRO = 32'((LARGURA_MIN + LARGURA_MAX) / 2);
  localparam logic [31:0] MIN_L          = 32'(LARGURA_MIN);
  localparam logic [31:0] PASSO_L        = 32'(PASSO);

  localparam logic [0:0] S_OCIOSO  = OCIOSO;
  localparam logic [0:0] S_MOVENDO = MOVENDO;

  logic [0:0]  estado;
  logic [31:0] alvo;
  logic [31:0] alvo_novo;
  logic        aceita;
  logic        tick_passo;

  // One step toward the target, never overshooting it.
  function automatic logic [31:0] passo_saturado(input logic [31:0] atual,
                                                 input logic [31:0] destino);
    logic [31:0] diff;
    if (destino > atual) begin
      diff = destino - atual;
      return atual + ((diff > PASSO_L) ? PASSO_L : diff);
    end else begin
      diff = atual - destino;
      return atual - ((diff > PASSO_L) ? PASSO_L : diff);
    end
  endfunction

  assign pos_ready = (estado == S_OCIOSO);
  assign movendo   = (estado == S_MOVENDO);
  assign aceita    = pos_valid && pos_ready;
  assign alvo_novo = MIN_L + 32'(satura_angulo(pos_angulo)) * PASSO_GRAU;

  contador_m #(
    .M(PERIODO_PASSO)
  ) u_contador_passo (
    .clock  (clock),
    .zera_as(~reset),
    .zera_s (aceita),
    .conta  (movendo),
    .fim    (tick_passo)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= S_OCIOSO;
      largura <= LARGURA_CENTRO;
      alvo    <= LARGURA_CENTRO;
      chegou  <= 1'b0;
    end else begin
      chegou <= 1'b0;
      if (estado == S_OCIOSO) begin
        if (aceita) begin
          alvo   <= alvo_novo;
          estado <= S_MOVENDO;
        end
      end else begin
        // Arrival wins over a coincident step tick.
        if (largura == alvo) begin
          chegou <= 1'b1;
          estado <= S_OCIOSO;
        end else if (tick_passo) begin
          largura <= passo_saturado(largura, alvo);
        end
      end
    end
  end

endmodule

// File: doc/posicionador_servo.md
# posicionador_servo

Slew-rate-limited position front end for the servo PWM path. Accepts an angle command (0–180°) through a valid/ready handshake and maps it to a target pulse width in clock ticks. It moves its `largura` output toward that target by at most `PASSO` ticks once every `PERIODO_PASSO` clocks, then pulses `chegou`. `largura` connects directly to the width input of the PWM generator, which sits immediately downstream.

## Interface
Parameters:
- `LARGURA_MIN`, default 50000: pulse width in ticks at 0° (1 ms at 50 MHz).
- `LARGURA_MAX`, default 100000: upper clamp of the pulse width (2 ms).
- `PASSO`, default 500: maximum change of `largura` per step, in ticks.
- `PERIODO_PASSO`, default 1000000: clocks between steps (one 20 ms PWM frame).
- Derived, not overridable: `PASSO_GRAU = (LARGURA_MAX-LARGURA_MIN)/180` (integer division); `LARGURA_CENTRO = (LARGURA_MIN+LARGURA_MAX)/2`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `pos_valid` in 1: command valid.
- `pos_ready` out 1: block can accept a command.
- `pos_angulo` in 8: commanded angle in degrees; values above 180 are clamped to 180.
- `largura` out 32: current pulse width in ticks, registered.
- `movendo` out 1: high while state is MOVENDO.
- `chegou` out 1: one-cycle pulse when `largura` reaches the target.

## Operation
- States: OCIOSO and MOVENDO.
- `pos_ready` = (state == OCIOSO), decoded combinationally from the state register. Commands are never accepted mid-move and are not queued.
- Acceptance occurs on a rising edge with `pos_valid && pos_ready`. On that edge:
  - `alvo <= LARGURA_MIN + min(pos_angulo,180)*PASSO_GRAU` (32-bit unsigned; the result is always ≤ `LARGURA_MAX`).
  - The step counter is cleared.
  - The state moves to MOVENDO.
- In MOVENDO, evaluated every cycle:
  - If `largura == alvo`: set `chegou <= 1` and state <= OCIOSO. This check takes priority over a step tick in the same cycle.
  - Else, on a step tick (step counter == `PERIODO_PASSO-1`): if `alvo > largura`, then `largura <= largura + min(PASSO, alvo-largura)`; otherwise `largura <= largura - min(PASSO, largura-alvo)`. The width never overshoots and never leaves [`LARGURA_MIN`, `LARGURA_MAX`].
  - The step counter wraps to 0 after `PERIODO_PASSO-1` and counts only in MOVENDO.
- `chegou` defaults to 0 every cycle it is not set.
- `movendo` is high exactly while state == MOVENDO.
- Async reset (`reset` low): state = OCIOSO, `largura` = `LARGURA_CENTRO`, `alvo` = `LARGURA_CENTRO`, step counter = 0, `chegou` = 0. Consequently `pos_ready` = 1 and `movendo` = 0. Reset mid-move aborts the move and `largura` jumps to the centre.

## Timing
- A command equal to the current width: accepted at edge t0, `chegou` high during cycle t1 to t2, `pos_ready` high again from t1.
- A move needs N = ceil(|alvo − largura| / PASSO) steps:
  - Step k lands at edge t0 + k·`PERIODO_PASSO`.
  - `chegou` is asserted on the edge one cycle after the last step.
  - Total latency from acceptance to `chegou` = N·`PERIODO_PASSO` + 1 clocks.
- `largura` changes only on step edges or on reset, so the PWM consumer can sample it at any time.
- `pos_valid` held high while `pos_ready` is low has no effect. A command presented in the same cycle that `chegou` is high is accepted, because `pos_ready` is already 1.

## Structure
- Shared package `servo_pkg` contains:
  - State enum `estado_posicionador_t` {OCIOSO, MOVENDO}.
  - `ANGULO_MAX = 180`.
  - Default timing constants `CLOCK_HZ = 50_000_000` and `PERIODO_PWM = 1_000_000`.
- Sub-module: the step tick comes from the team's `contador_m`, instantiated with M=`PERIODO_PASSO`.
  - `zera_as` = ~`reset`.
  - `zera_s` = acceptance.
  - `conta` = `movendo`.
  - `fim` is the step tick.
- All other logic (FSM, target mapping, saturating step) stays in `posicionador_servo`.

## Test plan
All scenarios use bench parameters MIN=100, MAX=280, PASSO=10, PERIODO_PASSO=4, giving PASSO_GRAU=1 and centre 190.
- Reset: hold `reset` low, then release. Required: `largura`=190, `pos_ready`=1, `movendo`=0, `chegou`=0. Assert reset again mid-move: `largura` returns to 190 immediately, without waiting for a clock edge.
- Move down: command 0° → `alvo`=100, 9 steps of −10. `largura` reads 180, 170, …, 100 at edges 4, 8, …, 36 after acceptance. `chegou` pulses once at edge 37.
- Non-multiple move: from 100, command 25° → `alvo`=125. Steps land at 110, 120, 125 (the last step is truncated). `chegou` pulses at edge 13.
- Clamp: command 200° → `alvo`=280. `largura` ends at exactly 280 and never exceeds it.
- Same target: from 190, command 90° → `alvo`=190. `chegou` pulses on the next cycle and `largura` is unchanged.
- Handshake: pulse `pos_valid` with other angles during a move. Required: each is ignored and the original target completes. A command presented during the `chegou` cycle is accepted.
